// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, ALU codes,
// IR field positions, FSM states, instruction classes and the control word.
package mini_src_pkg;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    localparam logic [4:0] OP_LD        = 5'b00000;
    localparam logic [4:0] OP_ST        = 5'b00010;
    localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01110;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'hF;
    localparam logic [3:0] ALU_DIV = 4'h0;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9,
        S_FAULT = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_MUL  = 3'd2,
        CLS_DIV  = 3'd3,
        CLS_LD   = 3'd4,
        CLS_ST   = 3'd5,
        CLS_HALT = 3'd6
    } instr_class_t;

    // One control step: every strobe the datapath sees in a single cycle.
    typedef struct packed {
        logic       pc_out;
        logic       zlo_out;
        logic       zhi_out;
        logic       mdr_out;
        logic       c_out;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       fault;
        logic [3:0] alu_op;
        logic       run;
    } ctrl_t;

endpackage

// File: rtl/mini_src_control_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. master = sequencer, slave = datapath side.
// Handshake: mem_ready is a single-cycle completion for the strobe (read or write)
// asserted in the same cycle; strobes stay high until a cycle with mem_ready = 1.
interface mini_src_control_sequencer_if;
    import mini_src_pkg::*;

    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;

    logic        pc_out;
    logic        zlo_out;
    logic        zhi_out;
    logic        mdr_out;
    logic        c_out;
    logic        mar_in;
    logic        pc_in;
    logic        mdr_in;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic        inc_pc;
    logic        read;
    logic        write;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        r_in;
    logic        r_out;
    logic        ba_out;
    logic [3:0]  alu_op;
    logic        run;
    logic        fault;
    state_t      dbg_state;

    modport master (
        input  ir, mem_ready, stop,
        output pc_out, zlo_out, zhi_out, mdr_out, c_out,
        output mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
        output inc_pc, read, write,
        output gra, grb, grc, r_in, r_out, ba_out,
        output alu_op, run, fault, dbg_state
    );

    modport slave (
        output ir, mem_ready, stop,
        input  pc_out, zlo_out, zhi_out, mdr_out, c_out,
        input  mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
        input  inc_pc, read, write,
        input  gra, grb, grc, r_in, r_out, ba_out,
        input  alu_op, run, fault, dbg_state
    );

endinterface

// File: rtl/mini_src_decode.sv
// Combinational opcode-to-instruction-class decode; unknown opcodes fall to NOP.
module mini_src_decode
    import mini_src_pkg::*;
(
    input  logic [4:0]   opcode_i,
    output instr_class_t class_o
);

    always_comb begin
        class_o = CLS_NOP;
        if (opcode_i == OP_LD) begin
            class_o = CLS_LD;
        end else if (opcode_i == OP_ST) begin
            class_o = CLS_ST;
        end else if (opcode_i >= OP_ALU_FIRST && opcode_i <= OP_ALU_LAST) begin
            class_o = CLS_ALU;
        end else if (opcode_i == OP_MUL) begin
            class_o = CLS_MUL;
        end else if (opcode_i == OP_DIV) begin
            class_o = CLS_DIV;
        end else if (opcode_i == OP_HALT) begin
            class_o = CLS_HALT;
        end else if (opcode_i == OP_NOP) begin
            class_o = CLS_NOP;
        end
    end

endmodule

// File: rtl/mini_src_control_sequencer.sv
// Mini SRC hardwired control sequencer: Moore FSM issuing one control step per clock.
// `define SEQ_TIMEOUT_EN adds a memory-wait watchdog and the absorbing FAULT state.
module mini_src_control_sequencer
    import mini_src_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic clear,
    mini_src_control_sequencer_if.master bus
);

    state_t       state_q;
    state_t       state_d;
    instr_class_t instr_class;
    logic [4:0]   opcode;
    ctrl_t        ctrl;
    logic         timed_out;
    logic         unused_ir_fields;

    assign opcode = bus.ir[IR_OP_MSB:IR_OP_LSB];

    // Register fields are decoded downstream from the same IR; only the opcode matters here.
    assign unused_ir_fields = ^{bus.ir[IR_RA_MSB:IR_RA_LSB], bus.ir[IR_RB_MSB:IR_RB_LSB],
                                bus.ir[IR_RC_MSB:IR_RC_LSB], bus.ir[IR_RC_LSB-1:0]};

    mini_src_decode u_decode (
        .opcode_i (opcode),
        .class_o  (instr_class)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             in_wait;

    // Counter is zero whenever the FSM is outside a wait state, so every entry starts fresh.
    always_comb begin
        in_wait    = (state_q == S_T1) ||
                     (state_q == S_T6 && instr_class == CLS_LD) ||
                     (state_q == S_T7 && instr_class == CLS_ST);
        wait_cnt_d = wait_cnt_q;
        timed_out  = 1'b0;
        if (!in_wait) begin
            wait_cnt_d = '0;
        end else if (!bus.mem_ready) begin
            if (wait_cnt_q != CNT_W'(MEM_TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            timed_out = (wait_cnt_q >= CNT_W'(MEM_TIMEOUT - 1));
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = bus.stop ? S_HALT : S_T1;
            S_T1: begin
                if (timed_out) begin
                    state_d = S_FAULT;
                end else if (bus.mem_ready) begin
                    state_d = S_T2;
                end
            end
            S_T2:    state_d = S_T3;
            S_T3: begin
                unique case (instr_class)
                    CLS_NOP:  state_d = S_T0;
                    CLS_HALT: state_d = S_HALT;
                    default:  state_d = S_T4;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (instr_class == CLS_ALU) ? S_T0 : S_T6;
            S_T6: begin
                if (instr_class == CLS_LD) begin
                    if (timed_out) begin
                        state_d = S_FAULT;
                    end else if (bus.mem_ready) begin
                        state_d = S_T7;
                    end
                end else if (instr_class == CLS_ST) begin
                    state_d = S_T7;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T7: begin
                if (instr_class == CLS_ST) begin
                    if (timed_out) begin
                        state_d = S_FAULT;
                    end else if (bus.mem_ready) begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = S_T0;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RESET;
        endcase
    end

    // Moore outputs: a function of the current step and the IR opcode only.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                unique case (instr_class)
                    CLS_ALU:         begin ctrl.grb = 1'b1; ctrl.r_out  = 1'b1; ctrl.y_in = 1'b1; end
                    CLS_MUL, CLS_DIV: begin ctrl.gra = 1'b1; ctrl.r_out  = 1'b1; ctrl.y_in = 1'b1; end
                    CLS_LD, CLS_ST:  begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (instr_class)
                    CLS_ALU: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                        ctrl.alu_op = opcode[3:0];
                    end
                    CLS_MUL: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                        ctrl.alu_op = ALU_MUL;
                    end
                    CLS_DIV: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                        ctrl.alu_op = ALU_DIV;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (instr_class)
                    CLS_ALU:          begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CLS_MUL, CLS_DIV: begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
                    CLS_LD, CLS_ST:   begin ctrl.zlo_out = 1'b1; ctrl.mar_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (instr_class)
                    CLS_MUL, CLS_DIV: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
                    CLS_LD:           begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                    CLS_ST:           begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                if (instr_class == CLS_LD) begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end else if (instr_class == CLS_ST) begin
                    ctrl.write = 1'b1;
                end
            end
`ifdef SEQ_TIMEOUT_EN
            S_FAULT: ctrl.fault = 1'b1;
`endif
            default: ;
        endcase
        ctrl.run = !(state_q == S_RESET || state_q == S_HALT || state_q == S_FAULT);
    end

    assign bus.pc_out    = ctrl.pc_out;
    assign bus.zlo_out   = ctrl.zlo_out;
    assign bus.zhi_out   = ctrl.zhi_out;
    assign bus.mdr_out   = ctrl.mdr_out;
    assign bus.c_out     = ctrl.c_out;
    assign bus.mar_in    = ctrl.mar_in;
    assign bus.pc_in     = ctrl.pc_in;
    assign bus.mdr_in    = ctrl.mdr_in;
    assign bus.ir_in     = ctrl.ir_in;
    assign bus.y_in      = ctrl.y_in;
    assign bus.z_in      = ctrl.z_in;
    assign bus.hi_in     = ctrl.hi_in;
    assign bus.lo_in     = ctrl.lo_in;
    assign bus.inc_pc    = ctrl.inc_pc;
    assign bus.read      = ctrl.read;
    assign bus.write     = ctrl.write;
    assign bus.gra       = ctrl.gra;
    assign bus.grb       = ctrl.grb;
    assign bus.grc       = ctrl.grc;
    assign bus.r_in      = ctrl.r_in;
    assign bus.r_out     = ctrl.r_out;
    assign bus.ba_out    = ctrl.ba_out;
    assign bus.alu_op    = ctrl.alu_op;
    assign bus.run       = ctrl.run;
    assign bus.fault     = ctrl.fault;
    assign bus.dbg_state = state_q;

endmodule
